if_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter. Each cycle it presents the current PC to the synchronous instruction memory, drives the PC's enable so the counter advances only when a fetch slot is free, and buffers returned instructions in a 2-entry FIFO. Decode consumes the FIFO through a valid/ready handshake. A flush input discards all in-flight and buffered fetches when a jump is taken.

---
 rtl/if_fetch_stage.sv | 91 +++++++++
 tb/tb_if_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one synchronous imem read per free slot and
// buffers returned instructions in a 2-entry FIFO drained by decode.
module if_fetch_stage #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               pc_en_o,
  output logic               imem_rd_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               flush_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o
);

  logic                         inflight_q, inflight_d;
  logic [ADDR_W-1:0]            inflight_pc_q, inflight_pc_d;
  logic [1:0][INSTR_W-1:0]      fifo_instr_q, fifo_instr_d;
  logic [1:0][ADDR_W-1:0]       fifo_pc_q, fifo_pc_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic [1:0]                   count_q, count_d;

  logic       pop, issue;
  logic [2:0] occ;

  // Occupancy after this edge if nothing new is issued; a slot is free below 2.
  assign pop   = instr_valid_o & instr_ready_i & ~flush_i;
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = ~flush_i & (occ < 3'd2);

  assign imem_addr_o   = pc_i;
  assign imem_rd_o     = issue & ~rst_i;
  assign pc_en_o       = (issue | flush_i) & ~rst_i;
  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = fifo_instr_q[rd_ptr_q];
  assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (flush_i) begin
      // Returning data and any handshake this cycle are dropped.
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) inflight_pc_d = pc_i;
      if (inflight_q) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata_i;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = occ[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fifo_instr_q  <= '0;
      fifo_pc_q     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural PC and imem (data = addr*3).
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc;
  logic        pc_en, imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [7:0]  jmp_tgt = '0;
  logic [7:0]  pc_rst_val = '0;
  int          total = 0;
  int          passed = 0;
  int          viol = 0;

  if_fetch_stage #(.INSTR_W(16), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_en_o(pc_en), .imem_rd_o(imem_rd),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata), .flush_i(flush),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .instr_o(instr),
    .instr_pc_o(instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) pc <= pc_rst_val;
    else if (pc_en) pc <= flush ? jmp_tgt : pc + 8'd1;

  always @(posedge clk)
    if (imem_rd) imem_rdata <= {8'h00, imem_addr} * 16'd3;

  always @(negedge clk)
    if (!rst && (({1'b0, dut.count_q} + {2'b00, dut.inflight_q}) > 3'd2)) viol++;

  task automatic do_reset(input logic [7:0] v);
    pc_rst_val = v;
    flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; instr_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en got=%b exp=0", pc_en); else passed++;
    total++; if (imem_rd !== 1'b0) $display("FAIL rst_imem_rd got=%b exp=0", imem_rd); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (instr !== 16'h0) $display("FAIL rst_instr got=%h exp=0", instr); else passed++;
    total++; if (instr_pc !== 8'h0) $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); else passed++;
    flush = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] ei [3] = '{16'h0000, 16'h0003, 16'h0006};
    logic [7:0]  ep [3] = '{8'h00, 8'h01, 8'h02};
    instr_ready = 1'b1;
    do_reset(8'h00); #1;
    total++; if ({imem_rd, pc_en, imem_addr} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL stream_first_issue got rd=%b en=%b addr=%h exp 1 1 00", imem_rd, pc_en, imem_addr); else passed++;
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_latency got valid=%b exp=0", instr_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if ({instr_valid, instr, instr_pc} !== {1'b1, ei[i], ep[i]})
        $display("FAIL stream_head%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", i, instr_valid, instr, instr_pc, ei[i], ep[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int nrd = 0;
    logic [7:0] addrs [4];
    instr_ready = 1'b0;
    do_reset(8'h00);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (imem_rd) begin
        if (nrd < 4) addrs[nrd] = imem_addr;
        nrd++;
      end
      @(negedge clk);
    end
    #1;
    total++; if (nrd !== 2) $display("FAIL bp_rd_pulses got=%0d exp=2", nrd); else passed++;
    total++; if ({addrs[0], addrs[1]} !== {8'h00, 8'h01})
      $display("FAIL bp_rd_addrs got=%h,%h exp=00,01", addrs[0], addrs[1]); else passed++;
    total++; if ({pc, pc_en} !== {8'h02, 1'b0}) $display("FAIL bp_pc_hold got pc=%h en=%b exp 02 0", pc, pc_en); else passed++;
    total++; if (dut.count_q !== 2'd2) $display("FAIL bp_count got=%0d exp=2", dut.count_q); else passed++;
    instr_ready = 1'b1; #1;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h0000, 8'h00})
      $display("FAIL bp_head0 got v=%b i=%h pc=%h exp 1 0000 00", instr_valid, instr, instr_pc); else passed++;
    @(negedge clk); #1;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h0003, 8'h01})
      $display("FAIL bp_head1 got v=%b i=%h pc=%h exp 1 0003 01", instr_valid, instr, instr_pc); else passed++;
    @(negedge clk); #1;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h0006, 8'h02})
      $display("FAIL bp_head2 got v=%b i=%h pc=%h exp 1 0006 02", instr_valid, instr, instr_pc); else passed++;
    instr_ready = 1'b0;
  endtask

  task automatic test_flush();
    instr_ready = 1'b0;
    do_reset(8'h00);
    repeat (4) @(negedge clk);
    flush = 1'b1; jmp_tgt = 8'h40; #1;
    total++; if ({pc_en, imem_rd} !== 2'b10) $display("FAIL flush_ctl got en=%b rd=%b exp 1 0", pc_en, imem_rd); else passed++;
    @(negedge clk); flush = 1'b0; instr_ready = 1'b1; #1;
    total++; if ({instr_valid, imem_rd, imem_addr} !== {1'b0, 1'b1, 8'h40})
      $display("FAIL flush_after got v=%b rd=%b addr=%h exp 0 1 40", instr_valid, imem_rd, imem_addr); else passed++;
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL flush_gap got valid=%b exp=0", instr_valid); else passed++;
    @(negedge clk); #1;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h00C0, 8'h40})
      $display("FAIL flush_target got v=%b i=%h pc=%h exp 1 00c0 40", instr_valid, instr, instr_pc); else passed++;
  endtask

  task automatic test_flush_handshake();
    instr_ready = 1'b1;
    do_reset(8'h00);
    repeat (3) @(negedge clk);
    flush = 1'b1; jmp_tgt = 8'h80; #1;
    total++; if ({instr_valid, pc_en, imem_rd} !== 3'b110)
      $display("FAIL fhs_ctl got v=%b en=%b rd=%b exp 1 1 0", instr_valid, pc_en, imem_rd); else passed++;
    @(negedge clk); flush = 1'b0; #1;
    total++; if ({instr_valid, dut.count_q, dut.inflight_q} !== {1'b0, 2'd0, 1'b0})
      $display("FAIL fhs_cleared got v=%b cnt=%0d inf=%b exp 0 0 0", instr_valid, dut.count_q, dut.inflight_q); else passed++;
    repeat (2) @(negedge clk); #1;
    total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h0180, 8'h80})
      $display("FAIL fhs_first got v=%b i=%h pc=%h exp 1 0180 80", instr_valid, instr, instr_pc); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] ei [4] = '{16'h02FA, 16'h02FD, 16'h0000, 16'h0003};
    logic [7:0]  ep [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    instr_ready = 1'b1;
    do_reset(8'hFE);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if ({instr_valid, instr, instr_pc} !== {1'b1, ei[i], ep[i]})
        $display("FAIL wrap%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", i, instr_valid, instr, instr_pc, ei[i], ep[i]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    do_reset(8'h00);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1; #1;
    total++; if ({instr_valid, pc_en, imem_rd} !== 3'b000)
      $display("FAIL arst_outputs got v=%b en=%b rd=%b exp 0 0 0", instr_valid, pc_en, imem_rd); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    total++; if ({imem_rd, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL arst_restart got rd=%b addr=%h exp 1 00", imem_rd, imem_addr); else passed++;
    repeat (2) @(negedge clk); #1;
    total++; if ({instr_valid, instr_pc} !== {1'b1, 8'h00})
      $display("FAIL arst_head got v=%b pc=%h exp 1 00", instr_valid, instr_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_handshake();
    test_wrap();
    test_async_reset();
    total++; if (viol !== 0) $display("FAIL occupancy_invariant got=%0d violations exp=0", viol); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
